m68k_bus_bridge: RTL
====================

# m68k_bus_bridge

Bridges the asynchronous 68000 CPU bus (AS/UDS/LDS/RW/DTACK/BERR) into the single-clock request/acknowledge bus consumed by the boot/SRAM memory stage. Sits directly upstream of the memory stage: synchronises CPU strobes, latches address/write data, presents a clean strobe pulse downstream, and returns read data plus DTACK to the CPU. An optional watchdog converts unacknowledged cycles into a CPU bus error.

## Interface
- TIMEOUT, 1023: cycles in ACCESS without `ack` before bus error (only with BUS_TIMEOUT_EN); counter width = $clog2(TIMEOUT+1).
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- cpu_addr  in  23  CPU A[23:1].
- cpu_data_in  in  16  CPU write data.
- cpu_data_out  out  16  read data to CPU pads.
- cpu_data_oe  out  1  high = bridge drives CPU data bus.
- cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw  in  1 each  raw asynchronous CPU strobes.
- cpu_dtack_n  out  1  data acknowledge, active-low.
- cpu_berr_n  out  1  bus error, active-low.
- addr  out  24  downstream byte address {cpu_addr, 1'b0}.
- data_write  out  16  latched write data.
- data_read  in  16  downstream read data.
- uds, lds  out  1 each  downstream byte strobes, active-low (0 = lane selected, 11 = idle).
- rw  out  1  1 = read, 0 = write.
- ack  in  1  downstream completion, sampled in ACCESS only.

## Operation
- cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw pass through two-flop synchronisers; FSM uses synchronised copies only. Address/data sampled directly (stable while AS low after sync delay).
- States: IDLE, ACCESS, DTACK, BERR.
- IDLE: uds=lds=1, dtack_n=1, berr_n=1, oe=0. When s_as_n=0 and (s_uds_n=0 or s_lds_n=0): latch addr, data_write, rw, and uds/lds from synced strobes -> ACCESS.
- ACCESS: uds/lds driven with latched lanes. On ack=1: if rw=1 capture data_read into cpu_data_out; release uds=lds=1; -> DTACK.
- DTACK: cpu_dtack_n=0; cpu_data_oe=rw. When s_as_n=1: dtack_n=1, oe=0 -> IDLE.
- BERR: cpu_berr_n=0, strobes idle. When s_as_n=1: berr_n=1 -> IDLE.
- AS asserted with both data strobes high (CPU address-only phase): stay IDLE.
- AS released while in ACCESS (CPU abort): release strobes, -> IDLE, no DTACK.
- Downstream strobes always return to 11 for >=1 cycle between accesses (guaranteed by IDLE), so downstream falling-edge detection sees every cycle.
- ack outside ACCESS ignored.

## Timing
- Reset values: uds=lds=1, rw=1, addr=0, data_write=0, cpu_data_out=0, cpu_data_oe=0, cpu_dtack_n=1, cpu_berr_n=1, state IDLE, sync flops = 1. Reset mid-cycle aborts immediately on next edge; no DTACK/BERR issued.
- CPU strobe fall -> downstream uds/lds low: 3 clk (2 sync + 1 register).
- ack high in cycle N -> strobes high and cpu_dtack_n low at edge N+1; cpu_data_out valid same edge.
- CPU AS rise -> cpu_dtack_n high: 3 clk.
- Timeout counter clears on ACCESS entry, increments each ACCESS cycle without ack; at count == TIMEOUT -> BERR next edge. ack in the same cycle as terminal count wins (DTACK).

## Configuration
- BUS_TIMEOUT_EN defined: watchdog counter and BERR state built; unacknowledged cycles end in bus error after TIMEOUT cycles.
- Undefined: no counter, BERR state absent, cpu_berr_n tied 1; ACCESS waits indefinitely for ack.

## Test plan
- Word read: AS/UDS/LDS low, rw=1, cpu_addr=0x000400>>1, ack pulsed 2 clk after strobes, data_read=0x4E71 -> addr=0x000400, uds=lds=0 for 2 clk, dtack_n=0, cpu_data_out=0x4E71, oe=1; AS high -> dtack_n=1 after 3 clk, oe=0.
- Byte write odd lane: UDS_n=1, LDS_n=0, rw=0, data 0x00A5 -> uds=1, lds=0, rw=0, data_write=0x00A5; dtack after ack; oe stays 0.
- Back-to-back writes of 0xA9A9 to address 0 -> uds/lds go 11 for >=1 clk between the two accesses; two separate acks/dtacks.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT=15): read, ack never asserted -> berr_n=0 at 16th ACCESS cycle, dtack_n stays 1, strobes released; AS high -> berr_n=1. Same with ack at terminal cycle -> dtack, no berr.
- Reset asserted during ACCESS -> next edge all outputs at reset values; following ack ignored.
- AS low with UDS/LDS high for 20 clk -> no downstream strobe, dtack_n=1.

Source files
------------

// File: rtl/m68k_bus_bridge.sv
// -----------------------------------------------------------------------------
// m68k_bus_bridge
//
// Purpose:
//   Bridges the asynchronous 68000 CPU bus (AS/UDS/LDS/RW/DTACK/BERR) onto the
//   single-clock request/acknowledge bus of the boot/SRAM memory stage. CPU
//   strobes are brought in through two-flop synchronisers, the address and
//   write data are latched when a cycle starts, a clean active-low byte-strobe
//   pair is presented downstream, and read data plus DTACK are returned to the
//   CPU.
//
// Configuration macro:
//   BUS_TIMEOUT_EN - when defined, a watchdog counts ACCESS cycles without
//                    ack_i and ends the cycle with a CPU bus error after
//                    TIMEOUT cycles. When undefined there is no counter, no
//                    BERR state, cpu_berr_n_o is tied high and ACCESS waits
//                    for ack_i indefinitely.
//
// Parameters:
//   TIMEOUT          ACCESS cycles without ack_i before bus error.
//
// Ports:
//   clk_i            system clock (single domain)
//   reset_n_i        synchronous active-low reset
//   cpu_addr_i       CPU A[23:1]
//   cpu_data_in_i    CPU write data
//   cpu_data_out_o   read data towards the CPU pads
//   cpu_data_oe_o    1 = bridge drives the CPU data bus
//   cpu_as_n_i       raw asynchronous CPU address strobe
//   cpu_uds_n_i      raw asynchronous CPU upper data strobe
//   cpu_lds_n_i      raw asynchronous CPU lower data strobe
//   cpu_rw_i         raw asynchronous CPU read/write (1 = read)
//   cpu_dtack_n_o    data acknowledge to the CPU, active-low
//   cpu_berr_n_o     bus error to the CPU, active-low
//   addr_o           downstream byte address {cpu_addr, 1'b0}
//   data_write_o     latched write data
//   data_read_i      downstream read data
//   uds_o, lds_o     downstream byte strobes, active-low (11 = idle)
//   rw_o             downstream direction (1 = read)
//   ack_i            downstream completion, honoured in ACCESS only
// -----------------------------------------------------------------------------
module m68k_bus_bridge #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [22:0] cpu_addr_i,
  input  logic [15:0] cpu_data_in_i,
  output logic [15:0] cpu_data_out_o,
  output logic        cpu_data_oe_o,
  input  logic        cpu_as_n_i,
  input  logic        cpu_uds_n_i,
  input  logic        cpu_lds_n_i,
  input  logic        cpu_rw_i,
  output logic        cpu_dtack_n_o,
  output logic        cpu_berr_n_o,
  output logic [23:0] addr_o,
  output logic [15:0] data_write_o,
  input  logic [15:0] data_read_i,
  output logic        uds_o,
  output logic        lds_o,
  output logic        rw_o,
  input  logic        ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
`ifdef BUS_TIMEOUT_EN
    ST_DTACK  = 2'd2,
    ST_BERR   = 2'd3
`else
    ST_DTACK  = 2'd2
`endif
  } state_e;

  // Synchroniser stages, bit order {as, uds, lds, rw}.
  logic [3:0]  meta_q;
  logic [3:0]  sync_q;
  logic        as_s;
  logic        uds_s;
  logic        lds_s;
  logic        rw_s;

  state_e      state_q;
  state_e      state_d;
  logic [23:0] addr_q;
  logic [23:0] addr_d;
  logic [15:0] data_write_q;
  logic [15:0] data_write_d;
  logic [15:0] data_out_q;
  logic [15:0] data_out_d;
  logic        rw_q;
  logic        rw_d;
  logic        uds_q;
  logic        uds_d;
  logic        lds_q;
  logic        lds_d;
  logic        dtack_n_q;
  logic        dtack_n_d;
  logic        oe_q;
  logic        oe_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             berr_n_q;
  logic             berr_n_d;
`else
  // Without the watchdog TIMEOUT has no function; keep it referenced.
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
`endif

  assign as_s  = sync_q[3];
  assign uds_s = sync_q[2];
  assign lds_s = sync_q[1];
  assign rw_s  = sync_q[0];

  // Two-flop synchronisers for the asynchronous CPU strobes (idle high).
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= {cpu_as_n_i, cpu_uds_n_i, cpu_lds_n_i, cpu_rw_i};
      sync_q <= meta_q;
    end
  end

  // Next-state and registered-output computation for the bridge FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_write_d = data_write_q;
    data_out_d   = data_out_q;
    rw_d         = rw_q;
    uds_d        = uds_q;
    lds_d        = lds_q;
    dtack_n_d    = dtack_n_q;
    oe_d         = oe_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d        = cnt_q;
    berr_n_d     = berr_n_q;
`endif

    case (state_q)
      ST_IDLE: begin
        dtack_n_d = 1'b1;
        oe_d      = 1'b0;
`ifdef BUS_TIMEOUT_EN
        berr_n_d  = 1'b1;
`endif
        // An AS with both data strobes high is an address-only phase.
        if (!as_s && (!uds_s || !lds_s)) begin
          state_d      = ST_ACCESS;
          addr_d       = {cpu_addr_i, 1'b0};
          data_write_d = cpu_data_in_i;
          rw_d         = rw_s;
          uds_d        = uds_s;
          lds_d        = lds_s;
`ifdef BUS_TIMEOUT_EN
          cnt_d        = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
        end
      end

      ST_ACCESS: begin
        // CPU abort has priority: the CPU is no longer waiting for DTACK.
        if (as_s) begin
          state_d = ST_IDLE;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
        end else if (ack_i) begin
          state_d   = ST_DTACK;
          uds_d     = 1'b1;
          lds_d     = 1'b1;
          dtack_n_d = 1'b0;
          oe_d      = rw_q;
          if (rw_q) begin
            data_out_d = data_read_i;
          end else begin
            data_out_d = data_out_q;
          end
        end
`ifdef BUS_TIMEOUT_EN
        // ack_i is tested first, so an ack on the terminal count still wins.
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d  = ST_BERR;
          uds_d    = 1'b1;
          lds_d    = 1'b1;
          berr_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = ST_ACCESS;
        end
`endif
      end

      ST_DTACK: begin
        if (as_s) begin
          state_d   = ST_IDLE;
          dtack_n_d = 1'b1;
          oe_d      = 1'b0;
        end else begin
          state_d = ST_DTACK;
        end
      end

`ifdef BUS_TIMEOUT_EN
      ST_BERR: begin
        if (as_s) begin
          state_d  = ST_IDLE;
          berr_n_d = 1'b1;
        end else begin
          state_d = ST_BERR;
        end
      end
`endif

      default: begin
        state_d   = ST_IDLE;
        uds_d     = 1'b1;
        lds_d     = 1'b1;
        dtack_n_d = 1'b1;
        oe_d      = 1'b0;
`ifdef BUS_TIMEOUT_EN
        berr_n_d  = 1'b1;
`endif
      end
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= 24'h000000;
      data_write_q <= 16'h0000;
      data_out_q   <= 16'h0000;
      rw_q         <= 1'b1;
      uds_q        <= 1'b1;
      lds_q        <= 1'b1;
      dtack_n_q    <= 1'b1;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_write_q <= data_write_d;
      data_out_q   <= data_out_d;
      rw_q         <= rw_d;
      uds_q        <= uds_d;
      lds_q        <= lds_d;
      dtack_n_q    <= dtack_n_d;
      oe_q         <= oe_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Watchdog counter and bus-error output flops.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q    <= {CNT_W{1'b0}};
      berr_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      berr_n_q <= berr_n_d;
    end
  end

  assign cpu_berr_n_o = berr_n_q;
`else
  assign cpu_berr_n_o = 1'b1;
`endif

  assign addr_o         = addr_q;
  assign data_write_o   = data_write_q;
  assign cpu_data_out_o = data_out_q;
  assign cpu_data_oe_o  = oe_q;
  assign cpu_dtack_n_o  = dtack_n_q;
  assign rw_o           = rw_q;
  assign uds_o          = uds_q;
  assign lds_o          = lds_q;

endmodule
